cavlc_coeff_scan: RTL and testbench

- Consumer end of the intra 4x4 coefficient handshake. Captures one quantized 4x4 luma block (dctq_valid / cavlc_cnt_ready), zigzag-scans it, and computes the CAVLC statistics TotalCoeff, TrailingOnes and TotalZeros.
- Emits a per-block header, then the nonzero levels in reverse zigzag order with run_before, to the CAVLC bitstream writer.
- Pulses cavlc_cnt_ready only once the block is fully consumed, so the producer holds data until then.

---
 rtl/h264_cavlc_pkg.sv | 44 ++++
 rtl/cavlc_symbol_buf.sv | 35 +++
 rtl/cavlc_coeff_scan.sv | 188 ++++++++++++++++++
 tb/tb_cavlc_coeff_scan.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/h264_cavlc_pkg.sv
// Shared types for the CAVLC coefficient scanner: FSM states, buffered symbol
// layout, default widths and the 4x4 zigzag lookup.
package h264_cavlc_pkg;

    localparam int COEF_W_DEF = 15;
    localparam int POS_W_DEF  = 10;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        HDR,
        EMIT,
        ACK
    } state_t;

    typedef struct packed {
        logic signed [COEF_W_DEF-1:0] level;
        logic [3:0]                   run;
        logic                         t1;
    } sym_t;

    // Returns {row[1:0], col[1:0]} of zigzag position idx.
    function automatic logic [3:0] zz_rc(input logic [3:0] idx);
        case (idx)
            4'd0:    return 4'h0;
            4'd1:    return 4'h1;
            4'd2:    return 4'h4;
            4'd3:    return 4'h8;
            4'd4:    return 4'h5;
            4'd5:    return 4'h2;
            4'd6:    return 4'h3;
            4'd7:    return 4'h6;
            4'd8:    return 4'h9;
            4'd9:    return 4'hC;
            4'd10:   return 4'hD;
            4'd11:   return 4'hA;
            4'd12:   return 4'h7;
            4'd13:   return 4'hB;
            4'd14:   return 4'hE;
            default: return 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/cavlc_symbol_buf.sv
// 16-entry symbol store: level/t1 written at the current coefficient count,
// run written one entry behind once the gap to the next nonzero is known.
module cavlc_symbol_buf
    import h264_cavlc_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en_i,
    input  logic [3:0]                   wr_idx_i,
    input  logic signed [COEF_W_DEF-1:0] wr_level_i,
    input  logic                         wr_t1_i,
    input  logic                         run_en_i,
    input  logic [3:0]                   run_idx_i,
    input  logic [3:0]                   run_i,
    input  logic [3:0]                   rd_idx_i,
    output sym_t                         rd_o
);

    sym_t buf_q [16];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) buf_q[i] <= '0;
        end else begin
            if (wr_en_i) begin
                buf_q[wr_idx_i].level <= wr_level_i;
                buf_q[wr_idx_i].t1    <= wr_t1_i;
            end
            if (run_en_i) buf_q[run_idx_i].run <= run_i;
        end
    end

    assign rd_o = buf_q[rd_idx_i];

endmodule

// File: rtl/cavlc_coeff_scan.sv
// Captures a 4x4 block, reverse-zigzag scans it for CAVLC statistics, then
// emits a header and the nonzero levels; the producer is released only at the end.
module cavlc_coeff_scan
    import h264_cavlc_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEF,
    parameter int POS_W  = POS_W_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                dctq_valid_i,
    input  logic [POS_W-1:0]                    topleft_x_i,
    input  logic [POS_W-1:0]                    topleft_y_i,
    input  logic signed [0:3][0:3][COEF_W-1:0]  dctq_4x4_i,
    output logic                                cavlc_cnt_ready_o,
    output logic                                busy_o,
    output logic                                hdr_valid_o,
    input  logic                                hdr_ready_i,
    output logic [4:0]                          hdr_total_coeff_o,
    output logic [1:0]                          hdr_trailing_ones_o,
    output logic [3:0]                          hdr_total_zeros_o,
    output logic [POS_W-1:0]                    hdr_topleft_x_o,
    output logic [POS_W-1:0]                    hdr_topleft_y_o,
    output logic                                sym_valid_o,
    input  logic                                sym_ready_i,
    output logic signed [COEF_W-1:0]            sym_level_o,
    output logic [3:0]                          sym_run_o,
    output logic                                sym_t1_o,
    output logic                                sym_last_o
);

    state_t                              state_q, state_d;
    logic signed [0:3][0:3][COEF_W-1:0]  coef_q;
    logic [POS_W-1:0]                    x_q, y_q;
    logic [3:0]                          scan_idx_q, scan_idx_d;
    logic [3:0]                          emit_idx_q, emit_idx_d;
    logic [4:0]                          tc_q, tc_d;
    logic [1:0]                          t1_q, t1_d;
    logic [3:0]                          tz_q, tz_d;
    logic [3:0]                          run_q, run_d;
    logic                                seen_q, seen_d;
    logic                                t1_open_q, t1_open_d;

    logic                                capture;
    logic [3:0]                          rc;
    logic signed [COEF_W-1:0]            coef;
    logic                                abs_one;
    logic [4:0]                          tcm1;
    logic                                wr_en, wr_t1, run_en, is_last;
    sym_t                                rd_sym;

    assign rc      = zz_rc(scan_idx_q);
    assign coef    = coef_q[rc[3:2]][rc[1:0]];
    assign abs_one = (coef == COEF_W'(1)) || (coef == '1);
    assign tcm1    = tc_q - 5'd1;
    assign is_last = ({1'b0, emit_idx_q} == tcm1);

    always_comb begin
        state_d    = state_q;
        scan_idx_d = scan_idx_q;
        emit_idx_d = emit_idx_q;
        tc_d       = tc_q;
        t1_d       = t1_q;
        tz_d       = tz_q;
        run_d      = run_q;
        seen_d     = seen_q;
        t1_open_d  = t1_open_q;
        capture    = 1'b0;
        wr_en      = 1'b0;
        wr_t1      = 1'b0;
        run_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (dctq_valid_i) begin
                    capture    = 1'b1;
                    state_d    = SCAN;
                    scan_idx_d = 4'd15;
                    tc_d       = '0;
                    t1_d       = '0;
                    tz_d       = '0;
                    run_d      = '0;
                    seen_d     = 1'b0;
                    t1_open_d  = 1'b1;
                end
            end
            SCAN: begin
                if (coef == '0) begin
                    if (seen_q) begin
                        tz_d  = tz_q + 4'd1;
                        run_d = run_q + 4'd1;
                    end
                end else begin
                    // The gap behind the previous level is final once this level arrives.
                    seen_d = 1'b1;
                    wr_en  = 1'b1;
                    run_en = (tc_q != 5'd0);
                    run_d  = '0;
                    tc_d   = tc_q + 5'd1;
                    if (t1_open_q && abs_one && (t1_q != 2'd3)) begin
                        t1_d  = t1_q + 2'd1;
                        wr_t1 = 1'b1;
                    end else begin
                        t1_open_d = 1'b0;
                    end
                end
                if (scan_idx_q == 4'd0) state_d = HDR;
                else                    scan_idx_d = scan_idx_q - 4'd1;
            end
            HDR: begin
                // Lowest-index level takes the zeros below it; rewriting each stall cycle is harmless.
                run_en = (tc_q != 5'd0);
                if (hdr_ready_i) begin
                    state_d    = (tc_q != 5'd0) ? EMIT : ACK;
                    emit_idx_d = '0;
                end
            end
            EMIT: begin
                if (sym_ready_i) begin
                    if (is_last) state_d    = ACK;
                    else         emit_idx_d = emit_idx_q + 4'd1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            coef_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            scan_idx_q <= '0;
            emit_idx_q <= '0;
            tc_q       <= '0;
            t1_q       <= '0;
            tz_q       <= '0;
            run_q      <= '0;
            seen_q     <= 1'b0;
            t1_open_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            scan_idx_q <= scan_idx_d;
            emit_idx_q <= emit_idx_d;
            tc_q       <= tc_d;
            t1_q       <= t1_d;
            tz_q       <= tz_d;
            run_q      <= run_d;
            seen_q     <= seen_d;
            t1_open_q  <= t1_open_d;
            if (capture) begin
                coef_q <= dctq_4x4_i;
                x_q    <= topleft_x_i;
                y_q    <= topleft_y_i;
            end
        end
    end

    cavlc_symbol_buf u_buf (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en),
        .wr_idx_i   (tc_q[3:0]),
        .wr_level_i (coef),
        .wr_t1_i    (wr_t1),
        .run_en_i   (run_en),
        .run_idx_i  (tcm1[3:0]),
        .run_i      (run_q),
        .rd_idx_i   (emit_idx_q),
        .rd_o       (rd_sym)
    );

    assign busy_o              = (state_q != IDLE);
    assign cavlc_cnt_ready_o   = (state_q == ACK);
    assign hdr_valid_o         = (state_q == HDR);
    assign hdr_total_coeff_o   = tc_q;
    assign hdr_trailing_ones_o = t1_q;
    assign hdr_total_zeros_o   = tz_q;
    assign hdr_topleft_x_o     = x_q;
    assign hdr_topleft_y_o     = y_q;
    assign sym_valid_o         = (state_q == EMIT);
    assign sym_level_o         = sym_valid_o ? rd_sym.level : '0;
    assign sym_run_o           = sym_valid_o ? rd_sym.run   : '0;
    assign sym_t1_o            = sym_valid_o & rd_sym.t1;
    assign sym_last_o          = sym_valid_o & is_last;

endmodule

// File: tb/tb_cavlc_coeff_scan.sv
// Directed bench: per-block reference model from the CAVLC rules, checked on every handshake.
module tb_cavlc_coeff_scan;

    localparam int CW = 15;
    localparam int PW = 10;

    logic                            clk = 1'b0;
    logic                            rst = 1'b0;
    logic                            dctq_valid = 1'b0;
    logic [PW-1:0]                   tlx = '0, tly = '0;
    logic signed [0:3][0:3][CW-1:0]  coef_in = '0;
    logic                            cnt_ready, busy, hdr_valid, sym_valid;
    logic                            hdr_ready, sym_ready;
    logic [4:0]                      h_tc;
    logic [1:0]                      h_t1;
    logic [3:0]                      h_tz;
    logic [PW-1:0]                   h_x, h_y;
    logic signed [CW-1:0]            s_level;
    logic [3:0]                      s_run;
    logic                            s_t1, s_last;

    always #5 clk = ~clk;

    cavlc_coeff_scan #(.COEF_W(CW), .POS_W(PW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .dctq_valid_i        (dctq_valid),
        .topleft_x_i         (tlx),
        .topleft_y_i         (tly),
        .dctq_4x4_i          (coef_in),
        .cavlc_cnt_ready_o   (cnt_ready),
        .busy_o              (busy),
        .hdr_valid_o         (hdr_valid),
        .hdr_ready_i         (hdr_ready),
        .hdr_total_coeff_o   (h_tc),
        .hdr_trailing_ones_o (h_t1),
        .hdr_total_zeros_o   (h_tz),
        .hdr_topleft_x_o     (h_x),
        .hdr_topleft_y_o     (h_y),
        .sym_valid_o         (sym_valid),
        .sym_ready_i         (sym_ready),
        .sym_level_o         (s_level),
        .sym_run_o           (s_run),
        .sym_t1_o            (s_t1),
        .sym_last_o          (s_last)
    );

    typedef struct {int level; int run; bit t1; bit last;} esym_t;

    int    total = 0, bad = 0, cyc = 0;
    esym_t exp_q[$];
    int    exp_tc, exp_t1, exp_tz, exp_x, exp_y;
    int    hdr_cnt = 0, ack_cnt = 0;
    bit    sym_tog = 1'b0, hdr_dly = 1'b0;
    int    t_zero[16], t_two[16], t_ones[16], t_big[16], t_five[16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: list nonzero zigzag positions from high to low and derive everything from gaps.
    task automatic model(input int c[16], input int x, input int y);
        int    zz[16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
        int    nz[$];
        esym_t e;
        exp_q.delete();
        for (int k = 15; k >= 0; k--) if (c[zz[k]] != 0) nz.push_back(k);
        exp_tc = nz.size();
        exp_tz = (nz.size() == 0) ? 0 : nz[0] + 1 - nz.size();
        exp_t1 = 0;
        exp_x  = x;
        exp_y  = y;
        for (int i = 0; i < nz.size(); i++) begin
            e.level = c[zz[nz[i]]];
            e.t1    = (i == exp_t1) && (exp_t1 < 3) && (e.level == 1 || e.level == -1);
            if (e.t1) exp_t1++;
            e.last  = (i == nz.size() - 1);
            e.run   = e.last ? nz[i] : nz[i] - nz[i + 1] - 1;
            exp_q.push_back(e);
        end
    endtask

    initial begin : rdy_drv
        int hcnt;
        hcnt      = 0;
        hdr_ready = 1'b1;
        sym_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            hcnt      = hdr_valid ? hcnt + 1 : 0;
            hdr_ready = hdr_dly ? (hcnt > 3) : 1'b1;
            sym_ready = sym_tog ? ~sym_ready : 1'b1;
        end
    end

    logic        p_hv, p_hr, p_sv, p_sr;
    logic [30:0] p_hdr;
    logic [20:0] p_sym;

    always @(negedge clk) begin
        esym_t e;
        if (!rst) begin
            p_hv = 1'b0;
            p_sv = 1'b0;
        end else begin
            if (hdr_valid && sym_valid) check("hdr_sym_overlap", 1, 0);
            if (p_hv && !p_hr)
                check("hdr_stall_stable", int'({hdr_valid, h_tc, h_t1, h_tz, h_x, h_y}), int'({1'b1, p_hdr}));
            if (p_sv && !p_sr)
                check("sym_stall_stable", int'({sym_valid, s_level, s_run, s_t1, s_last}), int'({1'b1, p_sym}));
            if (hdr_valid && hdr_ready) begin
                hdr_cnt++;
                check("hdr_tc", int'(h_tc), exp_tc);
                check("hdr_t1", int'(h_t1), exp_t1);
                check("hdr_tz", int'(h_tz), exp_tz);
                check("hdr_x", int'(h_x), exp_x);
                check("hdr_y", int'(h_y), exp_y);
            end
            if (sym_valid && sym_ready) begin
                if (exp_q.size() == 0) begin
                    check("sym_extra", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sym_level", int'(s_level), e.level);
                    check("sym_run", int'(s_run), e.run);
                    check("sym_t1", int'(s_t1), int'(e.t1));
                    check("sym_last", int'(s_last), int'(e.last));
                end
            end
            if (cnt_ready) begin
                ack_cnt++;
                check("ack_syms_left", exp_q.size(), 0);
                check("ack_hdr_done", hdr_cnt, 1);
            end
            p_hv  = hdr_valid;
            p_hr  = hdr_ready;
            p_sv  = sym_valid;
            p_sr  = sym_ready;
            p_hdr = {h_tc, h_t1, h_tz, h_x, h_y};
            p_sym = {s_level, s_run, s_t1, s_last};
        end
    end

    task automatic present(input int c[16], input int x, input int y);
        @(posedge clk);
        #1;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) coef_in[r][k] = CW'(c[r * 4 + k]);
        tlx        = PW'(x);
        tly        = PW'(y);
        dctq_valid = 1'b1;
    endtask

    task automatic run_block(input string tag, input int c[16], input int x, input int y,
                             input int ptc, input int pt1, input int ptz, input bit chk_lat);
        int cap, guard;
        model(c, x, y);
        check({tag, "_model_tc"}, exp_tc, ptc);
        check({tag, "_model_t1"}, exp_t1, pt1);
        check({tag, "_model_tz"}, exp_tz, ptz);
        hdr_cnt = 0;
        ack_cnt = 0;
        present(c, x, y);
        @(posedge clk);
        #1;
        cap = cyc;
        check({tag, "_busy"}, int'(busy), 1);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!cnt_ready && guard < 300);
        if (!cnt_ready) check({tag, "_ack_timeout"}, 0, 1);
        @(posedge clk);
        #1;
        dctq_valid = 1'b0;
        if (chk_lat) check({tag, "_latency"}, cyc - cap, 18 + ptc);
        repeat (3) @(negedge clk);
        check({tag, "_ack_count"}, ack_cnt, 1);
        check({tag, "_hdr_count"}, hdr_cnt, 1);
        check({tag, "_syms_left"}, exp_q.size(), 0);
        check({tag, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        int lit_lv[5] = '{1, -1, -1, 1, 3};
        int lit_rn[5] = '{1, 0, 0, 1, 1};
        int lit_t1[5] = '{1, 1, 1, 0, 0};
        int guard;
        for (int i = 0; i < 16; i++) begin
            t_zero[i] = 0;
            t_two[i]  = 0;
            t_ones[i] = 1;
            t_big[i]  = 0;
            t_five[i] = 0;
        end
        t_two[1] = 3; t_two[2] = -1; t_two[5] = -1; t_two[6] = 1; t_two[8] = 1;
        t_big[15] = -2048;
        t_five[0] = 5;

        #2;
        check("rst_busy", int'(busy), 0);
        check("rst_hdr_valid", int'(hdr_valid), 0);
        check("rst_sym_valid", int'(sym_valid), 0);
        check("rst_cnt_ready", int'(cnt_ready), 0);
        check("rst_hdr_tc", int'(h_tc), 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;

        model(t_two, 0, 0);
        for (int i = 0; i < 5; i++) begin
            check("pin_level", exp_q[i].level, lit_lv[i]);
            check("pin_run", exp_q[i].run, lit_rn[i]);
            check("pin_t1", int'(exp_q[i].t1), lit_t1[i]);
        end

        run_block("zero", t_zero, 4, 8, 0, 0, 0, 1'b1);
        run_block("two", t_two, 16, 32, 5, 3, 3, 1'b1);
        run_block("ones", t_ones, 100, 200, 16, 3, 0, 1'b1);
        run_block("big", t_big, 1020, 12, 1, 0, 15, 1'b1);
        run_block("five", t_five, 0, 1023, 1, 0, 0, 1'b1);

        sym_tog = 1'b1;
        hdr_dly = 1'b1;
        run_block("two_stall", t_two, 44, 52, 5, 3, 3, 1'b0);

        model(t_two, 60, 64);
        hdr_cnt = 0;
        present(t_two, 60, 64);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (exp_q.size() > 3 && guard < 300);
        if (exp_q.size() > 3) check("rst_emit_timeout", 0, 1);
        check("pre_rst_in_emit", int'(sym_valid), 1);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_hdr_valid", int'(hdr_valid), 0);
        check("mid_rst_sym_valid", int'(sym_valid), 0);
        check("mid_rst_cnt_ready", int'(cnt_ready), 0);
        check("mid_rst_hdr", int'({h_tc, h_t1, h_tz, h_x, h_y}), 0);
        check("mid_rst_sym", int'({s_level, s_run, s_t1, s_last}), 0);
        dctq_valid = 1'b0;
        exp_q.delete();
        sym_tog = 1'b0;
        hdr_dly = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;

        run_block("ones_after_rst", t_ones, 7, 9, 16, 3, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
